// File: rtl/foo_pair_issue_if.sv
// Handshake bundle for foo_pair_issue: the 32-bit operand input stream and
// the result stream that comes out of the result FIFO.
interface foo_pair_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;

    // Producer of operands and consumer of results
    modport master (
        output in_valid,
        output in_data,
        output res_ready,
        input  in_ready,
        input  res_valid,
        input  res_data
    );

    // The pairing / collecting block itself
    modport slave (
        input  in_valid,
        input  in_data,
        input  res_ready,
        output in_ready,
        output res_valid,
        output res_data
    );
endinterface

// File: rtl/foo_pair_issue.sv
// foo_pair_issue: pairs consecutive operand words into the 64-bit input of
// the foo adder pipeline, tracks every issued pair through foo's fixed
// latency with a tag shift register, and collects returning sums into a
// small result FIFO. Issue is credit-limited so that the FIFO can never
// overflow: a credit is taken on issue and returned when a result is popped.
module foo_pair_issue #(
    parameter int LATENCY    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    foo_pair_issue_if.slave     bus,
    output logic [63:0]         s_out,
    input  logic [31:0]         sum_in,
    output logic                half_pending
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [AW-1:0] LAST_SLOT = AW'(FIFO_DEPTH - 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } pair_state_t;

    pair_state_t       state_reg;
    pair_state_t       state_next;
    logic [31:0]       held_reg;
    logic [LATENCY-1:0] vld_reg;
    logic [CW-1:0]     used_reg;
    logic [CW-1:0]     count_reg;
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [31:0]       mem_reg [FIFO_DEPTH];

    logic in_ready;
    logic accept;
    logic issue;
    logic push;
    logic pop;

    // Pair assembly is purely combinational: the held first word is foo's
    // 'a' operand, the word currently on the input bus is 'b'.
    assign s_out        = {held_reg, bus.in_data};
    assign half_pending = (state_reg == ST_HALF);

    assign accept = bus.in_valid && in_ready;
    assign issue  = accept && (state_reg == ST_HALF);
    assign push   = vld_reg[LATENCY-1];
    assign pop    = (count_reg != '0) && bus.res_ready;

    assign bus.in_ready  = in_ready;
    assign bus.res_valid = (count_reg != '0);
    assign bus.res_data  = mem_reg[rd_ptr_reg];

    // Pairing FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Pairing FSM next state and ready: a first word is always welcome, the
    // second one only while a credit is free (depends on registered state only)
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b1;
        case (state_reg)
            ST_EMPTY: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_next = ST_HALF;
                end
            end
            ST_HALF: begin
                in_ready = (used_reg < DEPTH_C);
                if (bus.in_valid && (used_reg < DEPTH_C)) begin
                    state_next = ST_EMPTY;
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
    end

    // Capture the first word of a pair; it stays on s_out[63:32] until replaced
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_reg <= '0;
        end else if (accept && (state_reg == ST_EMPTY)) begin
            held_reg <= bus.in_data;
        end
    end

    // Tag shift register mirroring foo's pipeline; only tagged sums are kept
    generate
        for (genvar gi = 0; gi < LATENCY; gi++) begin : g_tag
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_reg[gi] <= 1'b0;
                end else if (gi == 0) begin
                    vld_reg[gi] <= issue;
                end else begin
                    vld_reg[gi] <= vld_reg[(gi > 0) ? gi - 1 : 0];
                end
            end
        end
    endgenerate

    // Credit counter: pairs in flight plus results waiting in the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            used_reg <= '0;
        end else if (issue && !pop) begin
            used_reg <= used_reg + 1'b1;
        end else if (pop && !issue) begin
            used_reg <= used_reg - 1'b1;
        end
    end

    // FIFO occupancy and circular pointers; push and pop may coincide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == LAST_SLOT) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == LAST_SLOT) ? '0 : rd_ptr_reg + 1'b1;
            end
        end
    end

    // FIFO storage, one register per slot so the head reads zero after reset
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_reg[gi] <= '0;
                end else if (push && (wr_ptr_reg == AW'(gi))) begin
                    mem_reg[gi] <= sum_in;
                end
            end
        end
    endgenerate

    // Credits make an overflowing push impossible; catch it if it ever happens
    overflow_check: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (count_reg != DEPTH_C));

endmodule

// File: tb/tb_foo_pair_issue.sv
// Bench for foo_pair_issue. A behavioural model of foo (3-stage adder)
// drives sum_in. The reference model keeps a queue of expected sums, each
// with the cycle from which it should be visible, and derives ready/valid
// from pairing parity and the number of outstanding pairs.
module tb_foo_pair_issue;

    localparam int DEPTH = 4;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] s_out;
    logic [31:0] sum_in;
    logic        half_pending;

    always #5 clk = ~clk;

    foo_pair_issue_if bus_if ();

    foo_pair_issue #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus_if),
        .s_out        (s_out),
        .sum_in       (sum_in),
        .half_pending (half_pending)
    );

    // foo: a + b, three register stages, no reset
    logic [31:0] p0, p1, p2;
    always @(posedge clk) begin
        p0 <= s_out[63:32] + s_out[31:0];
        p1 <= p0;
        p2 <= p1;
    end
    assign sum_in = p2;

    typedef struct {
        logic [31:0] sum;
        int          rdy;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
    } vec_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        m_half;
    logic [31:0] m_held;
    int          n_popped = 0;
    int          last_issue_cyc = 0;
    logic        s_acc;
    logic        s_in_ready;
    logic        s_res_valid;
    logic [31:0] s_res_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive, check against the model mid-cycle, advance the model
    task automatic cycle(input logic iv, input logic [31:0] id, input logic rr);
        logic e_ir, e_rv, pop;
        bus_if.in_valid  = iv;
        bus_if.in_data   = id;
        bus_if.res_ready = rr;
        @(negedge clk);
        e_ir = !m_half || (q.size() < DEPTH);
        e_rv = (q.size() > 0) && (q[0].rdy <= cyc);
        chk("in_ready", 64'(bus_if.in_ready), 64'(e_ir));
        chk("half_pending", 64'(half_pending), 64'(m_half));
        chk("res_valid", 64'(bus_if.res_valid), 64'(e_rv));
        chk("s_out", s_out, {m_held, id});
        if (e_rv) chk("res_data", 64'(bus_if.res_data), 64'(q[0].sum));
        s_in_ready  = bus_if.in_ready;
        s_res_valid = bus_if.res_valid;
        s_res_data  = bus_if.res_data;
        s_acc       = iv && e_ir;
        pop         = e_rv && rr;
        @(posedge clk);
        #1;
        if (pop) begin
            $display("RES   cyc=%0d data=%h", cyc, q[0].sum);
            void'(q.pop_front());
            n_popped++;
        end
        if (s_acc) begin
            if (!m_half) begin
                m_held = id;
                m_half = 1'b1;
            end else begin
                q.push_back('{sum: m_held + id, rdy: cyc + 4});
                $display("ISSUE cyc=%0d a=%h b=%h", cyc, m_held, id);
                m_half = 1'b0;
                last_issue_cyc = cyc;
            end
        end
        cyc++;
    endtask

    task automatic send_word(input logic [31:0] w, input logic rr);
        int n = 0;
        do begin
            cycle(1'b1, w, rr);
            n++;
        end while (!s_acc && n < 60);
        chk("send_accept", 64'(s_acc), 64'd1);
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) cycle(1'b0, $urandom, rr);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 100) begin
            cycle(1'b0, $urandom, 1'b1);
            n++;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int   lat, n, k, c0, p0_cnt;

        tbl[0] = '{32'h0000_0005, 32'h0000_0007, 32'h0000_000C};
        tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
        tbl[2] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
        tbl[3] = '{32'h1234_5678, 32'h1111_1111, 32'h2345_6789};
        tbl[4] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        tbl[5] = '{32'hDEAD_BEEF, 32'h0000_0001, 32'hDEAD_BEF0};

        m_half = 1'b0;
        m_held = '0;
        rst_n  = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = 32'hA5A5_5A5A;
        bus_if.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus_if.in_ready), 64'd1);
        chk("rst_half", 64'(half_pending), 64'd0);
        chk("rst_res_valid", 64'(bus_if.res_valid), 64'd0);
        chk("rst_res_data", 64'(bus_if.res_data), 64'd0);
        chk("rst_s_hi", 64'(s_out[63:32]), 64'd0);
        rst_n = 1'b1;

        // Directed pairs: explicit sum and 4-cycle latency from second accept
        for (int i = 0; i < 6; i++) begin
            send_word(tbl[i].a, 1'b1);
            send_word(tbl[i].b, 1'b0);
            n = 0;
            do begin
                cycle(1'b0, $urandom, 1'b0);
                n++;
            end while (!s_res_valid && n < 12);
            lat = (cyc - 1) - last_issue_cyc;
            chk("latency", 64'(lat), 64'd4);
            chk("tbl_sum", 64'(s_res_data), 64'(tbl[i].sum));
            cycle(1'b0, $urandom, 1'b1);
        end

        // Sustained stream: 16 words back to back, no stall
        p0_cnt = n_popped;
        c0 = cyc;
        for (int i = 1; i <= 16; i++) send_word(32'(i), 1'b1);
        chk("stream_no_stall", 64'(cyc - c0), 64'd16);
        drain();
        chk("stream_results", 64'(n_popped - p0_cnt), 64'd8);

        // Back-pressure: consumer stalled, 12 words offered
        p0_cnt = n_popped;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(k < 12, 32'h100 + 32'(k), 1'b0);
            if (s_acc) k++;
        end
        chk("bp_accepted", 64'(k), 64'd9);
        chk("bp_in_ready", 64'(bus_if.in_ready), 64'd0);
        chk("bp_half", 64'(half_pending), 64'd1);
        chk("bp_res_valid", 64'(bus_if.res_valid), 64'd1);
        n = 0;
        while (k < 12 && n < 60) begin
            cycle(1'b1, 32'h100 + 32'(k), 1'b1);
            if (s_acc) k++;
            n++;
        end
        drain();
        chk("bp_results", 64'(n_popped - p0_cnt), 64'd6);

        // Push, pop and a pending second word all in one cycle
        for (int i = 0; i < 6; i++) send_word(32'h200 + 32'(i), 1'b0);
        idle(4, 1'b0);
        send_word(32'h300, 1'b0);
        send_word(32'h301, 1'b0);
        send_word(32'h400, 1'b0);
        idle(1, 1'b0);
        cycle(1'b1, 32'h401, 1'b1);
        chk("simul_in_ready", 64'(s_in_ready), 64'd0);
        chk("simul_res_valid", 64'(s_res_valid), 64'd1);
        send_word(32'h401, 1'b1);
        drain();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3) != 0);
        end
        drain();

        // Reset with two results queued, one pair in flight, one word held
        for (int i = 0; i < 7; i++) send_word(32'h500 + 32'(i), 1'b0);
        idle(1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_res_valid", 64'(bus_if.res_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(bus_if.in_ready), 64'd1);
        chk("mid_rst_half", 64'(half_pending), 64'd0);
        chk("mid_rst_s_hi", 64'(s_out[63:32]), 64'd0);
        q.delete();
        m_half = 1'b0;
        m_held = '0;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        idle(4, 1'b1);
        send_word(32'h0000_0005, 1'b1);
        send_word(32'h0000_0007, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
